// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that shares one data-memory channel among NUM_CONSUMERS LSUs.
// Optional watchdog on the memory handshake is enabled by defining LSU_ARB_TIMEOUT_EN.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS  = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  input  logic                     mem_write_ready,
  output logic                     timeout_error
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CONSUMERS - 1);

  state_t              state_reg;
  logic [IDX_BITS-1:0] grant_reg;
  logic [IDX_BITS-1:0] last_grant_reg;
  logic                op_read_reg;

  logic [NUM_CONSUMERS-1:0] req;
  logic                     found;
  logic                     pick_read;
  logic [IDX_BITS-1:0]      pick;
  logic [IDX_BITS-1:0]      cand;
  logic                     relay_done;

  generate
    for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_req
      assign req[gi] = consumer_read_valid[gi] | consumer_write_valid[gi];
    end
  endgenerate

  // Scan starts one past the previous winner so every requester is served within NUM_CONSUMERS grants.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_read = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      cand = IDX_BITS'((int'(last_grant_reg) + k) % NUM_CONSUMERS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        pick      = cand;
        pick_read = consumer_read_valid[cand];
      end
    end
  end

  assign relay_done = op_read_reg ? !consumer_read_valid[grant_reg]
                                  : !consumer_write_valid[grant_reg];

`ifdef LSU_ARB_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  logic [CNT_BITS-1:0] wait_cnt_reg;
  logic                expired;
  assign expired = (wait_cnt_reg == CNT_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_error  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= IDLE;
      grant_reg            <= '0;
      last_grant_reg       <= LAST_IDX;
      op_read_reg          <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) consumer_read_data[i] <= '0;
`ifdef LSU_ARB_TIMEOUT_EN
      wait_cnt_reg         <= '0;
      timeout_error        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            grant_reg      <= pick;
            last_grant_reg <= pick;
            op_read_reg    <= pick_read;
            if (pick_read) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick];
              state_reg        <= READ_WAIT;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick];
              mem_write_data    <= consumer_write_data[pick];
              state_reg         <= WRITE_WAIT;
            end
`ifdef LSU_ARB_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid                 <= 1'b0;
            consumer_read_data[grant_reg]  <= mem_read_data;
            consumer_read_ready[grant_reg] <= 1'b1;
            state_reg                      <= RELAY;
          end
`ifdef LSU_ARB_TIMEOUT_EN
          // A stuck memory read is acknowledged with zero data so the LSU never hangs.
          else if (expired) begin
            mem_read_valid                 <= 1'b0;
            consumer_read_data[grant_reg]  <= '0;
            consumer_read_ready[grant_reg] <= 1'b1;
            timeout_error                  <= 1'b1;
            state_reg                      <= RELAY;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_BITS'(1);
          end
`endif
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid                 <= 1'b0;
            consumer_write_ready[grant_reg] <= 1'b1;
            state_reg                       <= RELAY;
          end
`ifdef LSU_ARB_TIMEOUT_EN
          else if (expired) begin
            mem_write_valid                 <= 1'b0;
            consumer_write_ready[grant_reg] <= 1'b1;
            timeout_error                   <= 1'b1;
            state_reg                       <= RELAY;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_BITS'(1);
          end
`endif
        end
        RELAY: begin
          if (relay_done) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            state_reg            <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Randomised and directed bench for lsu_mem_arbiter against a queue-based round-robin/memory model.
// Runs the watchdog scenario when built with LSU_ARB_TIMEOUT_EN.
module tb_lsu_mem_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] crv, cwv, crr, cwr;
  logic [7:0]   cra [N];
  logic [7:0]   crd [N];
  logic [7:0]   cwa [N];
  logic [7:0]   cwd [N];
  logic         mrv, mwv, mrr, mwr, terr;
  logic [7:0]   mra, mrd, mwa, mwd;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(
    .NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
    .mem_write_ready(mwr), .timeout_error(terr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit checks_on = 0;

  // Memory: answers mem_lat cycles after it first sees a valid; contents reload to addr^0xBB on reset.
  logic [7:0] mem [256];
  int  mem_wait;
  bit  mem_en = 1;
  int  mem_lat = 0;
  always @(posedge clk) begin
    if (reset) begin
      mrr <= 1'b0; mwr <= 1'b0; mrd <= 8'h00; mem_wait <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hBB;
    end else begin
      mrr <= 1'b0; mwr <= 1'b0;
      if ((mrv || mwv) && !mrr && !mwr && mem_en) begin
        if (mem_wait >= mem_lat) begin
          mem_wait <= 0;
          if (mrv) begin mrr <= 1'b1; mrd <= mem[mra]; end
          else begin mwr <= 1'b1; mem[mwa] <= mwd; end
        end else begin
          mem_wait <= mem_wait + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checks_on && reset === 1'b0) begin
      checks++;
      if ((mrv && mwv) || $countones({crr, cwr}) > 1) begin
        errors++;
        $display("FAIL exclusive: mem valids r/w=%b/%b readys=%b/%b, required at most one of each", mrv, mwv, crr, cwr);
      end
    end
  end

  // Consumer driver state: 0 idle, 1 requesting, 2 holding valid after acknowledge.
  typedef struct { int idx; bit is_read; logic [7:0] data; } done_t;
  typedef struct { int idx; bit is_read; logic [7:0] addr; logic [7:0] wdata; } exp_t;
  int         c_st [N];
  int         c_hold [N];
  done_t      done_q [$];
  exp_t       exp_q [$];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rd [N];
  int         model_last;

  task tick();
    @(posedge clk); #1; cyc++;
  endtask

  task start_req(input int i, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d, input int hold);
    if (rd) begin crv[i] = 1'b1; cra[i] = a; end
    if (wr) begin cwv[i] = 1'b1; cwa[i] = a; cwd[i] = d; end
    c_st[i] = 1; c_hold[i] = hold;
  endtask

  task service();
    done_t e;
    for (int i = 0; i < N; i++) begin
      if (c_st[i] == 1 && (crr[i] || cwr[i])) begin
        e.idx = i; e.is_read = crr[i]; e.data = crd[i];
        done_q.push_back(e);
        $display("txn cycle=%0d consumer=%0d %s data=%h", cyc, i, crr[i] ? "read" : "write", crd[i]);
        if (c_hold[i] == 0) begin crv[i] = 1'b0; cwv[i] = 1'b0; c_st[i] = 0; end
        else c_st[i] = 2;
      end else if (c_st[i] == 2) begin
        c_hold[i]--;
        if (c_hold[i] == 0) begin crv[i] = 1'b0; cwv[i] = 1'b0; c_st[i] = 0; end
      end
    end
  endtask

  task apply_reset(input bit clear_cons);
    reset = 1'b1;
    if (clear_cons) begin
      crv = '0; cwv = '0;
      for (int i = 0; i < N; i++) begin
        c_st[i] = 0; c_hold[i] = 0; cra[i] = 8'h00; cwa[i] = 8'h00; cwd[i] = 8'h00;
      end
    end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hBB;
    for (int i = 0; i < N; i++) exp_rd[i] = 8'h00;
    done_q.delete(); exp_q.delete();
    model_last = N - 1;
    checks_on = 1;
  endtask

  task test_reset();
    apply_reset(1);
    checks++;
    if (mrv !== 1'b0 || mwv !== 1'b0 || mra !== 8'h00 || mwa !== 8'h00 || mwd !== 8'h00) begin
      errors++; $display("FAIL reset_mem: valids=%b%b addr=%h/%h wdata=%h, required all 0", mrv, mwv, mra, mwa, mwd);
    end
    checks++;
    if (crr !== 4'b0 || cwr !== 4'b0 || terr !== 1'b0) begin
      errors++; $display("FAIL reset_ready: rready=%b wready=%b timeout=%b, required 0", crr, cwr, terr);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (crd[i] !== 8'h00) begin errors++; $display("FAIL reset_rdata[%0d]: got %h, required 00", i, crd[i]); end
    end
    repeat (3) tick();
    checks++;
    if (mrv !== 1'b0 || mwv !== 1'b0) begin
      errors++; $display("FAIL idle_no_grant: valids=%b%b with no requests, required 00", mrv, mwv);
    end
  endtask

  task test_single_read();
    int n; bit got;
    apply_reset(1);
    mem_lat = 0; tick();
    start_req(2, 1, 0, 8'h10, 8'h00, 0);
    n = 0; got = 0;
    while (n < 20 && !got) begin
      tick(); n++;
      if (n == 1) begin
        checks++;
        if (mrv !== 1'b1 || mra !== 8'h10) begin
          errors++; $display("FAIL single_issue: valid=%b addr=%h, required 1/10", mrv, mra);
        end
      end
      if (crr[2]) got = 1;
    end
    checks++;
    if (!got || n != 3) begin errors++; $display("FAIL single_latency: got=%0d cycles=%0d, required ready after 3", got, n); end
    checks++;
    if (crd[2] !== 8'hAB) begin errors++; $display("FAIL single_data: got %h, required AB", crd[2]); end
    service(); tick(); tick();
    checks++;
    if (crr !== 4'b0) begin errors++; $display("FAIL single_release: rready=%b, required 0", crr); end
  endtask

  task test_contention();
    int n; bit rereq_pending; bit rereq_done; int exp_order [4]; logic [7:0] exp_addr [4];
    exp_order = '{0, 1, 3, 0};
    exp_addr  = '{8'h30, 8'h31, 8'h33, 8'h40};
    apply_reset(1);
    start_req(0, 1, 0, 8'h30, 8'h00, 0);
    start_req(1, 1, 0, 8'h31, 8'h00, 0);
    start_req(3, 1, 0, 8'h33, 8'h00, 0);
    n = 0; rereq_pending = 0; rereq_done = 0;
    while (n < 80 && done_q.size() < 4) begin
      tick(); n++;
      if (rereq_pending) begin start_req(0, 1, 0, 8'h40, 8'h00, 0); rereq_pending = 0; end
      service();
      if (!rereq_done && done_q.size() > 0) begin rereq_pending = 1; rereq_done = 1; end
    end
    checks++;
    if (done_q.size() != 4) begin
      errors++; $display("FAIL contention_count: got %0d completions in %0d cycles, required 4", done_q.size(), n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (done_q[k].idx != exp_order[k] || done_q[k].data !== ref_mem[exp_addr[k]]) begin
          errors++; $display("FAIL contention_order[%0d]: consumer %0d data %h, required consumer %0d data %h",
                             k, done_q[k].idx, done_q[k].data, exp_order[k], ref_mem[exp_addr[k]]);
        end
      end
    end
  endtask

  task test_mixed();
    int n;
    apply_reset(1);
    mem_lat = 1;
    start_req(1, 0, 1, 8'h20, 8'h55, 0);
    start_req(2, 1, 0, 8'h20, 8'h00, 0);
    n = 0;
    while (n < 60 && done_q.size() < 2) begin tick(); n++; service(); end
    checks++;
    if (done_q.size() != 2) begin
      errors++; $display("FAIL mixed_count: got %0d completions, required 2", done_q.size());
    end else begin
      checks++;
      if (done_q[0].idx != 1 || done_q[0].is_read) begin
        errors++; $display("FAIL mixed_first: consumer %0d read=%0d, required consumer 1 write", done_q[0].idx, done_q[0].is_read);
      end
      checks++;
      if (done_q[1].idx != 2 || !done_q[1].is_read || done_q[1].data !== 8'h55) begin
        errors++; $display("FAIL mixed_read: consumer %0d data %h, required consumer 2 data 55", done_q[1].idx, done_q[1].data);
      end
    end
    mem_lat = 0;
  endtask

  task test_slow_consumer();
    int n; int rdy_cnt; int busy_cnt;
    apply_reset(1);
    // hold=4: valid stays up for the acknowledge cycle plus four more, i.e. five cycles of ready.
    start_req(0, 1, 0, 8'h05, 8'h00, 4);
    start_req(1, 1, 0, 8'h06, 8'h00, 0);
    n = 0; rdy_cnt = 0; busy_cnt = 0;
    while (n < 60 && done_q.size() < 2) begin
      tick(); n++;
      if (crr[0]) begin
        rdy_cnt++;
        if (mrv || mwv || crr[1]) busy_cnt++;
      end
      service();
    end
    checks++;
    if (rdy_cnt != 5) begin errors++; $display("FAIL slow_ready_len: ready high %0d cycles, required 5", rdy_cnt); end
    checks++;
    if (busy_cnt != 0) begin errors++; $display("FAIL slow_no_grant: %0d cycles with another grant, required 0", busy_cnt); end
    checks++;
    if (done_q.size() != 2 || done_q[0].idx != 0 || done_q[1].idx != 1) begin
      errors++; $display("FAIL slow_order: %0d completions, required consumer 0 then 1", done_q.size());
    end
  endtask

  task test_reset_mid();
    int n; bit seen; bit zero_rd;
    apply_reset(1);
    start_req(1, 1, 0, 8'h01, 8'h00, 0);
    n = 0;
    while (n < 20 && done_q.size() < 1) begin tick(); n++; service(); end
    tick();
    mem_en = 0;
    start_req(3, 1, 0, 8'h12, 8'h00, 0);
    n = 0; seen = 0;
    while (n < 10 && !seen) begin tick(); n++; if (mrv) seen = 1; end
    checks++;
    if (!seen) begin errors++; $display("FAIL midreset_issue: no read issued, required mem_read_valid=1"); end
    tick(); tick();
    reset = 1'b1;
    tick();
    zero_rd = 1;
    for (int i = 0; i < N; i++) if (crd[i] !== 8'h00) zero_rd = 0;
    checks++;
    if (mrv !== 1'b0 || mwv !== 1'b0 || crr !== 4'b0 || cwr !== 4'b0 || mra !== 8'h00 || !zero_rd) begin
      errors++; $display("FAIL midreset_clear: valids=%b%b readys=%b/%b addr=%h rdata_zero=%0d, required all 0",
                         mrv, mwv, crr, cwr, mra, zero_rd);
    end
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hBB;
    done_q.delete();
    mem_en = 1;
    tick();
    checks++;
    if (mrv !== 1'b1 || mra !== 8'h12) begin
      errors++; $display("FAIL midreset_regrant: valid=%b addr=%h, required 1/12", mrv, mra);
    end
    n = 0;
    while (n < 20 && done_q.size() < 1) begin tick(); n++; service(); end
    checks++;
    if (done_q.size() != 1 || done_q[0].idx != 3 || done_q[0].data !== 8'hA9) begin
      errors++; $display("FAIL midreset_done: %0d completions, required consumer 3 data A9", done_q.size());
    end
  endtask

  task test_random();
    bit prev_busy, busy, hit; int c; int r; int hold; logic [7:0] a, d; done_t e; exp_t x;
    apply_reset(1);
    prev_busy = 0;
    for (int t = 0; t < 900; t++) begin
      tick();
      mem_lat = $urandom_range(0, 2);
      busy = mrv | mwv;
      if (busy && !prev_busy) begin
        hit = 0; c = 0;
        for (int k = 1; k <= N; k++) begin
          if (!hit && (crv[(model_last + k) % N] || cwv[(model_last + k) % N])) begin
            hit = 1; c = (model_last + k) % N;
          end
        end
        checks++;
        if (!hit) begin
          errors++; $display("FAIL rand_issue: grant with no requester, required none");
        end else begin
          x.idx = c; x.is_read = crv[c];
          x.addr = crv[c] ? cra[c] : cwa[c]; x.wdata = cwd[c];
          if (mrv !== x.is_read || mwv !== !x.is_read ||
              (x.is_read ? (mra !== x.addr) : (mwa !== x.addr || mwd !== x.wdata))) begin
            errors++; $display("FAIL rand_issue: rv=%b wv=%b ra=%h wa=%h wd=%h, required consumer %0d read=%0d addr=%h wdata=%h",
                               mrv, mwv, mra, mwa, mwd, c, x.is_read, x.addr, x.wdata);
          end
          exp_q.push_back(x);
          model_last = c;
        end
      end
      prev_busy = busy;
      service();
      while (done_q.size() > 0) begin
        e = done_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_done: consumer %0d acknowledged without a grant", e.idx);
        end else begin
          x = exp_q.pop_front();
          if (e.idx != x.idx || e.is_read != x.is_read || (x.is_read && e.data !== ref_mem[x.addr])) begin
            errors++; $display("FAIL rand_done: consumer %0d read=%0d data=%h, required consumer %0d read=%0d data=%h",
                               e.idx, e.is_read, e.data, x.idx, x.is_read, ref_mem[x.addr]);
          end
          if (x.is_read) exp_rd[x.idx] = e.data;
          else ref_mem[x.addr] = x.wdata;
          for (int j = 0; j < N; j++) begin
            if (j != x.idx) begin
              checks++;
              if (crd[j] !== exp_rd[j]) begin
                errors++; $display("FAIL rand_retain[%0d]: got %h, required %h", j, crd[j], exp_rd[j]);
              end
            end
          end
        end
      end
      if (t < 800) begin
        for (int i = 0; i < N; i++) begin
          if (c_st[i] == 0 && !crr[i] && !cwr[i] && $urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 3); a = 8'($urandom_range(0, 15)); d = 8'($urandom);
            hold = $urandom_range(0, 2);
            if (r == 0) start_req(i, 1, 1, a, d, hold);
            else if (r == 1) start_req(i, 1, 0, a, d, hold);
            else start_req(i, 0, 1, a, d, hold);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || c_st[0] != 0 || c_st[1] != 0 || c_st[2] != 0 || c_st[3] != 0) begin
      errors++; $display("FAIL rand_drain: %0d grants outstanding, states %0d%0d%0d%0d, required all idle",
                         exp_q.size(), c_st[0], c_st[1], c_st[2], c_st[3]);
    end
  endtask

`ifdef LSU_ARB_TIMEOUT_EN
  task test_timeout();
    int n;
    apply_reset(1);
    start_req(2, 1, 0, 8'h10, 8'h00, 0);
    n = 0;
    while (n < 20 && done_q.size() < 1) begin tick(); n++; service(); end
    tick();
    mem_en = 0;
    start_req(2, 1, 0, 8'h33, 8'h00, 0);
    n = 0;
    while (n < 30 && !crr[2]) begin tick(); n++; end
    // One edge to issue, then eight cycles without memory ready.
    checks++;
    if (n != 9) begin errors++; $display("FAIL timeout_latency: ready after %0d cycles, required 9", n); end
    checks++;
    if (crd[2] !== 8'h00 || terr !== 1'b1 || mrv !== 1'b0) begin
      errors++; $display("FAIL timeout_ack: data=%h err=%b mrv=%b, required 00/1/0", crd[2], terr, mrv);
    end
    service();
    repeat (5) tick();
    checks++;
    if (terr !== 1'b1 || crr !== 4'b0) begin
      errors++; $display("FAIL timeout_sticky: err=%b rready=%b, required 1/0", terr, crr);
    end
    mem_en = 1;
    apply_reset(1);
    checks++;
    if (terr !== 1'b0) begin errors++; $display("FAIL timeout_reset: err=%b, required 0", terr); end
  endtask
`else
  task test_timeout();
    checks++;
    if (terr !== 1'b0) begin errors++; $display("FAIL timeout_off: err=%b, required 0", terr); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    crv = '0; cwv = '0;
    for (int i = 0; i < N; i++) begin cra[i] = 8'h00; cwa[i] = 8'h00; cwd[i] = 8'h00; end
    test_reset();
    test_single_read();
    test_contention();
    test_mixed();
    test_slow_consumer();
    test_reset_mid();
    test_random();
    test_timeout();
    checks_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of LSU requesters sharing one data-memory channel.
REQ-002 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit used only under REQ-029.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 consumer_read_valid  input  [NUM_CONSUMERS]  per-LSU read request, held until acknowledged.
REQ-008 consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  per-LSU read address.
REQ-009 consumer_read_ready  output  [NUM_CONSUMERS]  per-LSU read acknowledge; read data is valid while high.
REQ-010 consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  per-LSU returned read data.
REQ-011 consumer_write_valid / consumer_write_address / consumer_write_data  input  [NUM_CONSUMERS] / [NUM_CONSUMERS][ADDR_BITS] / [NUM_CONSUMERS][DATA_BITS]  per-LSU write request, address and data.
REQ-012 consumer_write_ready  output  [NUM_CONSUMERS]  per-LSU write acknowledge.
REQ-013 mem_read_valid / mem_read_address  output  1 / ADDR_BITS  read request to memory.
REQ-014 mem_read_ready / mem_read_data  input  1 / DATA_BITS  memory read completion and data.
REQ-015 mem_write_valid / mem_write_address / mem_write_data  output  1 / ADDR_BITS / DATA_BITS  write request to memory.
REQ-016 mem_write_ready  input  1  memory write completion.
REQ-017 timeout_error  output  1  sticky watchdog flag.

Function
REQ-018 SHALL implement FSM states IDLE, READ_WAIT, WRITE_WAIT and RELAY, with all outputs registered.
REQ-019 IDLE: scan consumers round-robin starting at last_grant+1 (mod NUM_CONSUMERS); pick the first with read_valid or write_valid; read wins over write for the same consumer.
REQ-020 On a grant, the next edge SHALL set mem_read_valid=1 with the consumer's address (go READ_WAIT), or set mem_write_valid=1 with its address and data (go WRITE_WAIT), and record grant index and last_grant.
REQ-021 READ_WAIT: on mem_read_ready=1, the next edge SHALL clear mem_read_valid, latch mem_read_data into consumer_read_data[grant], set consumer_read_ready[grant]=1 and go RELAY.
REQ-022 WRITE_WAIT: on mem_write_ready=1, the next edge SHALL clear mem_write_valid, set consumer_write_ready[grant]=1 and go RELAY.
REQ-023 RELAY: hold ready until the granted consumer drops the corresponding valid; that edge SHALL clear ready and go IDLE.
REQ-024 Minimum latency from request to ready, with memory ready in the cycle after issue, SHALL be 3 cycles; throughput is at most one transaction per 4 cycles.
REQ-025 Requests arriving while the FSM is busy SHALL be held pending and never dropped; no consumer SHALL wait more than NUM_CONSUMERS grants.
REQ-026 At most one of mem_read_valid and mem_write_valid SHALL be high, and at most one consumer ready bit SHALL be high, in any cycle.
REQ-027 consumer_read_data[i] SHALL retain its last value until overwritten by a new read completion for consumer i.

Reset
REQ-028 While reset is high at an edge, the block SHALL go to IDLE, clear all mem valids, mem addresses, mem write data, consumer readys, consumer read data and timeout_error to 0, and set last_grant=NUM_CONSUMERS-1 so that consumer 0 is scanned first; this applies mid-transaction and cancels any outstanding memory request.

Configuration
REQ-029 Macro LSU_ARB_TIMEOUT_EN: when defined, a counter SHALL run in READ_WAIT/WRITE_WAIT; after TIMEOUT_CYCLES cycles without memory ready, the block SHALL drop the mem valid, acknowledge the consumer (read data 0), set timeout_error=1 until reset, and go RELAY. When undefined, there SHALL be no counter, the wait is unbounded, and timeout_error SHALL be constant 0.

Verification
REQ-030 Single read: consumer 2 reads address 0x10, memory returns 0xAB one cycle after issue -> mem_read_address=0x10, consumer_read_ready[2]=1 with data 0xAB 3 cycles after the request.
REQ-031 Contention: consumers 0, 1 and 3 request simultaneously from reset -> grant order 0, 1, 3; then a new request from 0 is granted only after 1 and 3.
REQ-032 Mixed: consumer 1 writes 0x55 to 0x20 while consumer 2 reads 0x20 -> write issued first, read returns 0x55; mem valids never overlap.
REQ-033 Slow consumer: consumer 0 holds read_valid 5 cycles after ready -> ready stays high 5 cycles; no other grant is issued meanwhile.
REQ-034 Reset in READ_WAIT -> next cycle all valids and readys are 0, FSM is IDLE, and the pending consumer is re-granted after reset.
REQ-035 With LSU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never ready -> after 8 cycles consumer ready=1 with data 0x00, timeout_error=1 and sticky.
